alu_issue: RTL and testbench

Command issue stage directly upstream of the ALU. It buffers incoming operation commands in a small FIFO and drives the ALU's valid_i/opcode/funct/a/b inputs from registers. Combinational opcodes issue back-to-back at one per cycle. A shift command (opcode 4'b0011) is multi-cycle, so after issuing one the stage holds the ALU inputs stable until the ALU's valid_o returns or a watchdog expires.

---
 rtl/alu_issue.sv | 141 ++++++++++++++
 tb/tb_alu_issue.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: command issue stage in front of the ALU.
// Accepted commands are queued in a small FIFO and issued to the ALU from
// registered outputs, one per cycle for combinational opcodes. After a shift
// (opcode 4'b0011) is issued, its operands are held on the ALU inputs until
// the ALU reports valid_o or a watchdog gives up on it.
module alu_issue #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 64,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [2:0]       cmd_funct,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  output logic             alu_valid_i,
  output logic [3:0]       alu_opcode,
  output logic [2:0]       alu_funct,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic             alu_valid_o,
  input  logic             err_clr,
  output logic             timeout_err,
  output logic [CNT_W-1:0] level,
  output logic             busy
);

  localparam int AW      = $clog2(DEPTH);
  localparam int WC_W    = $clog2(MAX_WAIT);
  localparam int ENTRY_W = 4 + 3 + 32 + 32;
  localparam logic [3:0] OP_SHIFT = 4'b0011;

  typedef enum logic {IDLE, WAIT_SHIFT} state_t;

  state_t             state_reg;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]   level_reg;
  logic [WC_W-1:0]    wait_cnt_reg;
  logic               alu_valid_i_reg;
  logic [3:0]         alu_opcode_reg;
  logic [2:0]         alu_funct_reg;
  logic [31:0]        alu_a_reg;
  logic [31:0]        alu_b_reg;
  logic               timeout_err_reg;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Ready depends only on occupancy, so a pop in the same cycle never frees a full FIFO early.
  assign cmd_ready = (level_reg != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_reg == IDLE) && (level_reg != '0);
  assign head      = mem[rd_ptr_reg];

  assign alu_valid_i = alu_valid_i_reg;
  assign alu_opcode  = alu_opcode_reg;
  assign alu_funct   = alu_funct_reg;
  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign timeout_err = timeout_err_reg;
  assign level       = level_reg;
  assign busy        = (level_reg != '0) || alu_valid_i_reg || (state_reg == WAIT_SHIFT);

  // FIFO storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_opcode, cmd_funct, cmd_a, cmd_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Issue FSM: pops and issues in IDLE, holds ALU inputs while a shift is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      alu_valid_i_reg <= 1'b0;
      alu_opcode_reg  <= '0;
      alu_funct_reg   <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      // A clear is overridden below when a timeout lands in the same cycle.
      if (err_clr) timeout_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            alu_valid_i_reg <= 1'b1;
            alu_opcode_reg  <= head[70:67];
            alu_funct_reg   <= head[66:64];
            alu_a_reg       <= head[63:32];
            alu_b_reg       <= head[31:0];
            if (head[70:67] == OP_SHIFT) begin
              state_reg    <= WAIT_SHIFT;
              wait_cnt_reg <= '0;
            end
          end else begin
            alu_valid_i_reg <= 1'b0;
          end
        end
        WAIT_SHIFT: begin
          alu_valid_i_reg <= 1'b0;
          if (alu_valid_o) begin
            state_reg <= IDLE;
          end else if (wait_cnt_reg == WC_W'(MAX_WAIT - 1)) begin
            // Give up on the shift; it is dropped rather than replayed.
            timeout_err_reg <= 1'b1;
            state_reg       <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed scenarios plus a randomized stream checked
// against a queue-based model of accepted-but-not-yet-issued commands.
module tb_alu_issue;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 64;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [2:0]       cmd_funct;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic             alu_valid_i;
  logic [3:0]       alu_opcode;
  logic [2:0]       alu_funct;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_valid_o;
  logic             err_clr;
  logic             timeout_err;
  logic [CNT_W-1:0] level;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Model: commands accepted by the stage and not yet seen on the ALU port.
  logic [70:0] acc_q[$];
  bit          last_acc;

  alu_issue #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_funct(cmd_funct), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_valid_i(alu_valid_i), .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_a(alu_a), .alu_b(alu_b), .alu_valid_o(alu_valid_o),
    .err_clr(err_clr), .timeout_err(timeout_err), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive_cmd(input logic v, input logic [3:0] op, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] b);
    cmd_valid  = v;
    cmd_opcode = op;
    cmd_funct  = f;
    cmd_a      = a;
    cmd_b      = b;
  endtask

  // One clock: note acceptance before the edge, return 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    last_acc = cmd_valid && cmd_ready;
    if (last_acc) acc_q.push_back({cmd_opcode, cmd_funct, cmd_a, cmd_b});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_valid_o = 1'b0;
    err_clr = 1'b0;
    drive_cmd(1'b0, 4'd0, 3'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({alu_valid_i, alu_opcode, alu_funct, alu_a, alu_b} !== 72'd0) begin
      errors++;
      $display("FAIL reset_alu: got %h expected 0", {alu_valid_i, alu_opcode, alu_funct, alu_a, alu_b});
    end
    checks++;
    if ({level, timeout_err, busy} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_status: got level=%0d err=%b busy=%b expected 0/0/0", level, timeout_err, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    end
    $display("reset: released, level=%0d ready=%b", level, cmd_ready);
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_vi_a [5];
    acc_q.delete();
    // {alu_valid_i, alu_a} after each of five edges
    exp_vi_a[0] = {1'b0, 32'd0};
    exp_vi_a[1] = {1'b1, 32'd1};
    exp_vi_a[2] = {1'b1, 32'd2};
    exp_vi_a[3] = {1'b1, 32'd3};
    exp_vi_a[4] = {1'b0, 32'd3};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive_cmd(1'b1, 4'd0, 3'd0, 32'(i + 1), 32'd1);
      else       cmd_valid = 1'b0;
      tick();
      checks++;
      if ({alu_valid_i, alu_a} !== exp_vi_a[i]) begin
        errors++;
        $display("FAIL b2b_issue[%0d]: got vi=%b a=%0d expected vi=%b a=%0d",
                 i, alu_valid_i, alu_a, exp_vi_a[i][32], exp_vi_a[i][31:0]);
      end
      $display("b2b: edge %0d vi=%b a=%0d level=%0d", i, alu_valid_i, alu_a, level);
    end
    checks++;
    if ({level, busy} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_drain: got level=%0d busy=%b expected 0/0", level, busy);
    end
  endtask

  task automatic test_shift_hold();
    acc_q.delete();
    drive_cmd(1'b1, 4'd3, 3'd0, 32'h1, 32'd4);
    tick();
    drive_cmd(1'b1, 4'd0, 3'd0, 32'd7, 32'd1);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({alu_valid_i, alu_opcode, alu_a} !== {1'b1, 4'd3, 32'd1}) begin
      errors++;
      $display("FAIL shift_issue: got vi=%b op=%0d a=%0d expected 1/3/1", alu_valid_i, alu_opcode, alu_a);
    end
    for (int k = 1; k <= 5; k++) begin
      alu_valid_o = (k == 5);
      tick();
      checks++;
      if ({alu_valid_i, alu_opcode, alu_a, busy} !== {1'b0, 4'd3, 32'd1, 1'b1}) begin
        errors++;
        $display("FAIL shift_hold[%0d]: got vi=%b op=%0d a=%0d busy=%b expected 0/3/1/1",
                 k, alu_valid_i, alu_opcode, alu_a, busy);
      end
    end
    alu_valid_o = 1'b0;
    tick();
    checks++;
    if ({alu_valid_i, alu_opcode, alu_a} !== {1'b1, 4'd0, 32'd7}) begin
      errors++;
      $display("FAIL shift_next_issue: got vi=%b op=%0d a=%0d expected 1/0/7", alu_valid_i, alu_opcode, alu_a);
    end
    $display("shift: add issued after response, a=%0d", alu_a);
    tick();
    checks++;
    if ({alu_valid_i, busy, level} !== {1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL shift_idle: got vi=%b busy=%b level=%0d expected 0/0/0", alu_valid_i, busy, level);
    end
  endtask

  task automatic test_timeout();
    acc_q.delete();
    drive_cmd(1'b1, 4'd3, 3'd1, 32'd5, 32'd2);
    tick();
    drive_cmd(1'b1, 4'd0, 3'd0, 32'd9, 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k < MAX_WAIT; k++) begin
      tick();
      checks++;
      if ({timeout_err, alu_valid_i, alu_a} !== {1'b0, 1'b0, 32'd5}) begin
        errors++;
        $display("FAIL timeout_early[%0d]: got err=%b vi=%b a=%0d expected 0/0/5", k, timeout_err, alu_valid_i, alu_a);
      end
    end
    tick();
    checks++;
    if ({timeout_err, alu_valid_i} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_set: got err=%b vi=%b expected 1/0", timeout_err, alu_valid_i);
    end
    tick();
    checks++;
    if ({alu_valid_i, alu_a, timeout_err} !== {1'b1, 32'd9, 1'b1}) begin
      errors++;
      $display("FAIL timeout_next: got vi=%b a=%0d err=%b expected 1/9/1", alu_valid_i, alu_a, timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 0", timeout_err);
    end
    $display("timeout: flagged and cleared, next cmd a=9 issued");
    // Second shift with err_clr held: the timeout must still win.
    err_clr = 1'b1;
    drive_cmd(1'b1, 4'd3, 3'd0, 32'd6, 32'd1);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int k = 1; k < MAX_WAIT; k++) tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clr_held: got %b expected 0", timeout_err);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set_wins: got %b expected 1", timeout_err);
    end
    err_clr = 1'b0;
    tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear2: got %b expected 0", timeout_err);
    end
  endtask

  task automatic test_full();
    logic [70:0] exp;
    int issues;
    int acc5;
    acc_q.delete();
    drive_cmd(1'b1, 4'd3, 3'd2, 32'hABCD, 32'd3);
    tick();
    drive_cmd(1'b1, 4'd0, 3'd1, 32'd101, 32'd1);
    tick();
    checks++;
    exp = acc_q.pop_front();
    if ({alu_valid_i, alu_opcode, alu_funct, alu_a, alu_b} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL full_shift_issue: got vi=%b %h expected vi=1 %h", alu_valid_i,
               {alu_opcode, alu_funct, alu_a, alu_b}, exp);
    end
    for (int i = 2; i <= 4; i++) begin
      drive_cmd(1'b1, 4'd0, 3'(i), 32'(100 + i), 32'(i));
      tick();
      checks++;
      if (last_acc !== 1'b1) begin
        errors++;
        $display("FAIL full_accept[%0d]: got %b expected 1", i, last_acc);
      end
    end
    checks++;
    if ({level, cmd_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_level: got level=%0d ready=%b expected 4/0", level, cmd_ready);
    end
    drive_cmd(1'b1, 4'd0, 3'd5, 32'd105, 32'd5);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({last_acc, level, alu_valid_i} !== {1'b0, 3'd4, 1'b0}) begin
        errors++;
        $display("FAIL full_stall[%0d]: got acc=%b level=%0d vi=%b expected 0/4/0", k, last_acc, level, alu_valid_i);
      end
    end
    alu_valid_o = 1'b1;
    tick();
    alu_valid_o = 1'b0;
    // Pop of c1 while full: c5 must still not be taken on this edge.
    tick();
    checks++;
    exp = acc_q.pop_front();
    if ({last_acc, alu_valid_i, alu_opcode, alu_funct, alu_a, alu_b} !== {1'b0, 1'b1, exp}) begin
      errors++;
      $display("FAIL full_pop_no_push: got acc=%b vi=%b %h expected acc=0 vi=1 %h", last_acc, alu_valid_i,
               {alu_opcode, alu_funct, alu_a, alu_b}, exp);
    end
    issues = 1;
    acc5 = 0;
    for (int t = 0; t < 30 && issues < 5; t++) begin
      tick();
      if (last_acc) begin
        acc5++;
        cmd_valid = 1'b0;
      end
      if (alu_valid_i) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL full_extra_issue: got a=%0d expected none", alu_a);
        end else begin
          exp = acc_q.pop_front();
          if ({alu_opcode, alu_funct, alu_a, alu_b} !== exp) begin
            errors++;
            $display("FAIL full_order: got %h expected %h", {alu_opcode, alu_funct, alu_a, alu_b}, exp);
          end
        end
        $display("full: issued a=%0d", alu_a);
        issues++;
      end
    end
    tick();
    checks++;
    if (issues !== 5 || acc5 !== 1 || level !== 3'd0 || acc_q.size() !== 0) begin
      errors++;
      $display("FAIL full_count: got issues=%0d acc5=%0d level=%0d left=%0d expected 5/1/0/0",
               issues, acc5, level, acc_q.size());
    end
  endtask

  task automatic test_reset_mid_shift();
    acc_q.delete();
    drive_cmd(1'b1, 4'd3, 3'd3, 32'h77, 32'd2);
    tick();
    drive_cmd(1'b1, 4'd1, 3'd0, 32'd11, 32'd1);
    tick();
    drive_cmd(1'b1, 4'd2, 3'd0, 32'd12, 32'd1);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({level, alu_opcode, busy} !== {3'd2, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_pre: got level=%0d op=%0d busy=%b expected 2/3/1", level, alu_opcode, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({alu_valid_i, alu_opcode, alu_funct, alu_a, alu_b, level, busy, timeout_err, cmd_ready} !==
        {72'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async: got vi=%b op=%0d a=%h level=%0d busy=%b err=%b ready=%b expected zeros, ready=1",
               alu_valid_i, alu_opcode, alu_a, level, busy, timeout_err, cmd_ready);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({alu_valid_i, level, busy} !== {1'b0, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL rstmid_after[%0d]: got vi=%b level=%0d busy=%b expected 0/0/0", k, alu_valid_i, level, busy);
      end
    end
    $display("reset_mid_shift: queue discarded, level=%0d", level);
    acc_q.delete();
  endtask

  task automatic test_random();
    int sent = 0;
    int wait_left = 0;
    int cyc = 0;
    int issued = 0;
    logic [3:0] op;
    logic [70:0] exp;
    acc_q.delete();
    drive_cmd(1'b0, 4'd0, 3'd0, 32'd0, 32'd0);
    last_acc = 1'b0;
    while (cyc < 20000) begin
      if (sent == 200 && !cmd_valid && acc_q.size() == 0 && wait_left == 0 && !busy) break;
      if (cmd_valid && last_acc) cmd_valid = 1'b0;
      if (!cmd_valid && sent < 200 && $urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 3) == 0) op = 4'd3;
        else begin
          op = 4'($urandom_range(0, 15));
          if (op == 4'd3) op = 4'd4;
        end
        drive_cmd(1'b1, op, 3'($urandom_range(0, 7)), $urandom, $urandom);
        sent++;
      end
      // Response only while a shift is outstanding; otherwise random noise that must be ignored.
      if (wait_left == 1)      alu_valid_o = 1'b1;
      else if (wait_left == 0) alu_valid_o = ($urandom_range(0, 4) == 0);
      else                     alu_valid_o = 1'b0;
      tick();
      cyc++;
      if (wait_left > 0) begin
        checks++;
        if ({alu_valid_i, alu_opcode} !== {1'b0, 4'd3}) begin
          errors++;
          $display("FAIL rand_wait_hold: got vi=%b op=%0d expected 0/3", alu_valid_i, alu_opcode);
        end
        wait_left--;
      end else if (alu_valid_i) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_issue: got op=%0d a=%h expected none", alu_opcode, alu_a);
        end else begin
          exp = acc_q.pop_front();
          issued++;
          if ({alu_opcode, alu_funct, alu_a, alu_b} !== exp) begin
            errors++;
            $display("FAIL rand_order[%0d]: got %h expected %h", issued, {alu_opcode, alu_funct, alu_a, alu_b}, exp);
          end
          if (exp[70:67] == 4'd3) wait_left = $urandom_range(1, 10);
          $display("rand: issue %0d op=%0d a=%h b=%h", issued, alu_opcode, alu_a, alu_b);
        end
      end
      checks++;
      if (int'(level) != acc_q.size() || cmd_ready !== (acc_q.size() != DEPTH)) begin
        errors++;
        $display("FAIL rand_level: got level=%0d ready=%b expected level=%0d", level, cmd_ready, acc_q.size());
      end
    end
    alu_valid_o = 1'b0;
    checks++;
    if (cyc >= 20000 || issued != 200) begin
      errors++;
      $display("FAIL rand_total: got issued=%0d cycles=%0d expected 200 issued", issued, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shift_hold();
    test_timeout();
    test_full();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
